// File: rtl/ccm_arbiter.sv
// ccm_arbiter
//   Shares one single-port closely-coupled memory macro (32-bit words,
//   1-cycle synchronous read, no byte enables) between the instruction-fetch
//   unit and the load/store unit. One access is granted per cycle; read data
//   is routed back to whichever unit owned the read. LSU partial stores are
//   executed as a read cycle followed by a merged full-word write cycle.
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   ifu_req/ifu_addr         IFU read request, held until ifu_gnt
//   ifu_gnt                  IFU request accepted this cycle (combinational)
//   ifu_rvalid/ifu_rdata     IFU read data, one cycle after ifu_gnt
//   lsu_req/lsu_we/lsu_addr  LSU request, held with its data until lsu_gnt
//   lsu_be/lsu_wdata         store byte enables and word-aligned store data
//   lsu_gnt                  LSU request accepted this cycle (combinational)
//   lsu_rvalid/lsu_rdata     LSU load data, one cycle after lsu_gnt (loads)
//   mem_adr/mem_d/mem_we     macro word address, write data, write enable
//   mem_q                    macro read data (cycle after the read address)
module ccm_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_d,
    output logic        mem_we,
    input  logic [31:0] mem_q
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, RMW_WR} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

    state_t             state_reg, state_next;
    owner_t             owner_reg, owner_next;
    logic [CNT_W-1:0]   starve_reg, starve_next;
    logic [ADDR_W-1:0]  rmw_addr_reg, rmw_addr_next;
    logic [3:0]         rmw_be_reg, rmw_be_next;
    logic [31:0]        rmw_wdata_reg, rmw_wdata_next;

    logic               ifu_win, lsu_win, starve_full;
    logic               lsu_full_store, lsu_partial_store;
    logic [31:0]        merged_data;

    // Word addresses: drop the byte offset and everything above the macro depth.
    logic [ADDR_W-1:0]  ifu_word, lsu_word;
    assign ifu_word = ifu_addr[ADDR_W+1:2];
    assign lsu_word = lsu_addr[ADDR_W+1:2];

    assign starve_full       = (starve_reg == CNT_W'(STARVE_LIMIT));
    assign lsu_full_store    = lsu_we && (lsu_be == 4'hF);
    assign lsu_partial_store = lsu_we && (lsu_be != 4'hF) && (lsu_be != 4'h0);

    // Arbitration: LSU has priority unless the IFU has been passed over
    // STARVE_LIMIT times in a row. No grants during reset or the RMW write.
    assign ifu_win = !RST && (state_reg == IDLE) && ifu_req &&
                     (!lsu_req || starve_full);
    assign lsu_win = !RST && (state_reg == IDLE) && lsu_req && !ifu_win;

    // Read-modify-write merge: enabled lanes from the latched store data,
    // the rest from the word read back during the grant cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_data[8*gi +: 8] = rmw_be_reg[gi] ? rmw_wdata_reg[8*gi +: 8]
                                                            : mem_q[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_NONE;
            starve_reg    <= '0;
            rmw_addr_reg  <= '0;
            rmw_be_reg    <= '0;
            rmw_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            starve_reg    <= starve_next;
            rmw_addr_reg  <= rmw_addr_next;
            rmw_be_reg    <= rmw_be_next;
            rmw_wdata_reg <= rmw_wdata_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        owner_next     = OWN_NONE;
        starve_next    = starve_reg;
        rmw_addr_next  = rmw_addr_reg;
        rmw_be_next    = rmw_be_reg;
        rmw_wdata_next = rmw_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (ifu_win)
                    owner_next = OWN_IFU;
                else if (lsu_win && !lsu_we)
                    owner_next = OWN_LSU;

                if (ifu_win || !ifu_req)
                    starve_next = '0;
                else if (lsu_win && !starve_full)
                    starve_next = starve_reg + CNT_W'(1);

                if (lsu_win && lsu_partial_store) begin
                    state_next     = RMW_WR;
                    rmw_addr_next  = lsu_word;
                    rmw_be_next    = lsu_be;
                    rmw_wdata_next = lsu_wdata;
                end
            end
            RMW_WR: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ifu_gnt    = ifu_win;
        lsu_gnt    = lsu_win;
        mem_adr    = '0;
        mem_d      = '0;
        mem_we     = 1'b0;
        ifu_rvalid = !RST && (owner_reg == OWN_IFU);
        lsu_rvalid = !RST && (owner_reg == OWN_LSU);
        ifu_rdata  = ifu_rvalid ? mem_q : '0;
        lsu_rdata  = lsu_rvalid ? mem_q : '0;
        if (!RST) begin
            if (state_reg == RMW_WR) begin
                mem_adr = {{(32-ADDR_W){1'b0}}, rmw_addr_reg};
                mem_d   = merged_data;
                mem_we  = 1'b1;
            end else if (ifu_win) begin
                mem_adr = {{(32-ADDR_W){1'b0}}, ifu_word};
            end else if (lsu_win) begin
                // Partial stores and loads read here; be=0 is a harmless read.
                mem_adr = {{(32-ADDR_W){1'b0}}, lsu_word};
                if (lsu_full_store) begin
                    mem_d  = lsu_wdata;
                    mem_we = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccm_arbiter.sv
module tb_ccm_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [3:0]  lsu_be = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [31:0] mem_adr, mem_d, mem_q;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    ccm_arbiter #(.ADDR_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_be(lsu_be), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 CLK = ~CLK;

    // Memory macro model with a side port for preloading.
    logic [31:0] mem_array [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_adr = '0;
    logic [31:0] pre_d = '0;
    always @(posedge CLK) begin
        if (pre_we)
            mem_array[pre_adr] <= pre_d;
        else if (mem_we)
            mem_array[mem_adr[15:0]] <= mem_d;
        mem_q <= mem_array[mem_adr[15:0]];
    end

    // Reference: word contents as the specification says they should be.
    logic [31:0] ref_mem [int];

    logic [133:0] all_outs;
    assign all_outs = {ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid,
                       lsu_rdata, mem_adr, mem_d, mem_we};

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        pre_we = 1'b1; pre_adr = 16'(w); pre_d = v;
        tick();
        pre_we = 1'b0;
        ref_mem[w] = v;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (wd & mask);
    endfunction

    task automatic test_reset;
        RST = 1'b1;
        tick(); tick();
        ifu_req = 1'b1; ifu_addr = 32'h10; lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF;
        @(negedge CLK);
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL reset_outs: got %h want 0", all_outs);
        end
        tick();
        RST = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0;
        @(negedge CLK);
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL idle_outs: got %h want 0", all_outs);
        end
        $display("reset: outputs idle");
        tick();
    endtask

    task automatic test_ifu_read;
        preload(4, 32'hDEADBEEF);
        ifu_req = 1'b1; ifu_addr = 32'h10;
        @(negedge CLK);
        total++;
        if ({ifu_gnt, mem_adr, mem_we} !== {1'b1, 32'd4, 1'b0}) begin
            bad++; $display("FAIL ifu_grant: got gnt=%b adr=%h we=%b want 1/4/0", ifu_gnt, mem_adr, mem_we);
        end
        tick();
        ifu_req = 1'b0;
        @(negedge CLK);
        total++;
        if ({ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            bad++; $display("FAIL ifu_rdata: got v=%b d=%h lv=%b ld=%h want 1/deadbeef/0/0",
                            ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata);
        end
        $display("ifu read 0x10 -> %h", ifu_rdata);
        tick();
    endtask

    task automatic test_full_store;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h40; lsu_be = 4'hF; lsu_wdata = 32'h12345678;
        @(negedge CLK);
        total++;
        if ({lsu_gnt, mem_we, mem_adr, mem_d} !== {1'b1, 1'b1, 32'h10, 32'h12345678}) begin
            bad++; $display("FAIL full_store: got gnt=%b we=%b adr=%h d=%h want 1/1/10/12345678",
                            lsu_gnt, mem_we, mem_adr, mem_d);
        end
        tick();
        lsu_req = 1'b0; lsu_we = 1'b0;
        ifu_req = 1'b1; ifu_addr = 32'h40;
        @(negedge CLK);
        total++;
        if ({lsu_rvalid, ifu_gnt, mem_we} !== 3'b010) begin
            bad++; $display("FAIL store_after: got lrv=%b ignt=%b we=%b want 0/1/0", lsu_rvalid, ifu_gnt, mem_we);
        end
        tick();
        ifu_req = 1'b0;
        @(negedge CLK);
        total++;
        if (ifu_rdata !== 32'h12345678) begin
            bad++; $display("FAIL store_readback: got %h want 12345678", ifu_rdata);
        end
        $display("lsu store 0x40 = 12345678, readback %h", ifu_rdata);
        tick();
    endtask

    task automatic test_partial_store;
        preload(8, 32'h11223344);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h20; lsu_be = 4'b0010; lsu_wdata = 32'h0000AB00;
        ifu_req = 1'b1; ifu_addr = 32'h20;
        @(negedge CLK);
        total++;
        if ({lsu_gnt, ifu_gnt, mem_we, mem_adr} !== {1'b1, 1'b0, 1'b0, 32'd8}) begin
            bad++; $display("FAIL rmw_read: got lg=%b ig=%b we=%b adr=%h want 1/0/0/8", lsu_gnt, ifu_gnt, mem_we, mem_adr);
        end
        tick();
        lsu_req = 1'b0; lsu_we = 1'b0;
        @(negedge CLK);
        total++;
        if ({mem_we, mem_d, mem_adr, ifu_gnt, lsu_gnt, lsu_rvalid} !== {1'b1, 32'h1122AB44, 32'd8, 3'b000}) begin
            bad++; $display("FAIL rmw_write: got we=%b d=%h adr=%h ig=%b lg=%b lrv=%b want 1/1122ab44/8/0/0/0",
                            mem_we, mem_d, mem_adr, ifu_gnt, lsu_gnt, lsu_rvalid);
        end
        tick();
        @(negedge CLK);
        total++;
        if ({ifu_gnt, mem_we} !== 2'b10) begin
            bad++; $display("FAIL rmw_then_ifu: got ig=%b we=%b want 1/0", ifu_gnt, mem_we);
        end
        tick();
        ifu_req = 1'b0;
        @(negedge CLK);
        total++;
        if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'h1122AB44}) begin
            bad++; $display("FAIL rmw_merged_read: got v=%b d=%h want 1/1122ab44", ifu_rvalid, ifu_rdata);
        end
        $display("partial store 0x20 be=0010 -> %h", ifu_rdata);
        tick();
    endtask

    task automatic test_starvation;
        bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        preload(32'h20, 32'hA1A1A1A1);
        preload(32'h21, 32'hB2B2B2B2);
        ifu_req = 1'b1; ifu_addr = 32'h80;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h84;
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            if (i < 10) begin
                total++;
                if ({ifu_gnt, lsu_gnt} !== {exp_i[i], !exp_i[i]}) begin
                    bad++; $display("FAIL starve_gnt[%0d]: got i=%b l=%b want i=%b l=%b",
                                    i, ifu_gnt, lsu_gnt, exp_i[i], !exp_i[i]);
                end
                $display("starve cycle %0d grant %s", i, ifu_gnt ? "I" : (lsu_gnt ? "L" : "-"));
            end
            if (i > 0) begin
                total++;
                if ({ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata} !==
                    {exp_i[i-1], !exp_i[i-1],
                     exp_i[i-1] ? 32'hA1A1A1A1 : 32'h0, exp_i[i-1] ? 32'h0 : 32'hB2B2B2B2}) begin
                    bad++; $display("FAIL starve_rvalid[%0d]: got iv=%b lv=%b id=%h ld=%h want iv=%b",
                                    i, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, exp_i[i-1]);
                end
            end
            tick();
            if (i == 9) begin
                ifu_req = 1'b0; lsu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_rmw;
        preload(12, 32'hCAFEF00D);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h30; lsu_be = 4'b0001; lsu_wdata = 32'h000000AA;
        @(negedge CLK);
        total++;
        if ({lsu_gnt, mem_we} !== 2'b10) begin
            bad++; $display("FAIL rst_rmw_grant: got lg=%b we=%b want 1/0", lsu_gnt, mem_we);
        end
        tick();
        lsu_req = 1'b0; lsu_we = 1'b0; RST = 1'b1;
        @(negedge CLK);
        total++;
        if (mem_we !== 1'b0) begin
            bad++; $display("FAIL rst_rmw_we: got %b want 0", mem_we);
        end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL rst_rmw_outs: got %h want 0", all_outs);
        end
        tick();
        ifu_req = 1'b1; ifu_addr = 32'h30;
        tick();
        ifu_req = 1'b0;
        @(negedge CLK);
        total++;
        if (ifu_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL rst_rmw_mem: got %h want cafef00d", ifu_rdata);
        end
        $display("reset during rmw: word 0x30 = %h", ifu_rdata);
        tick();
    endtask

    task automatic test_be_zero;
        preload(20, 32'h5555AAAA);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h50; lsu_be = 4'h0; lsu_wdata = 32'hFFFFFFFF;
        @(negedge CLK);
        total++;
        if ({lsu_gnt, mem_we} !== 2'b10) begin
            bad++; $display("FAIL be0_grant: got lg=%b we=%b want 1/0", lsu_gnt, mem_we);
        end
        tick();
        lsu_req = 1'b0; lsu_we = 1'b0;
        @(negedge CLK);
        total++;
        if ({lsu_rvalid, mem_we} !== 2'b00) begin
            bad++; $display("FAIL be0_after: got lrv=%b we=%b want 0/0", lsu_rvalid, mem_we);
        end
        tick();
        ifu_req = 1'b1; ifu_addr = 32'h50;
        tick();
        ifu_req = 1'b0;
        @(negedge CLK);
        total++;
        if (ifu_rdata !== 32'h5555AAAA) begin
            bad++; $display("FAIL be0_mem: got %h want 5555aaaa", ifu_rdata);
        end
        $display("be=0 store: word 0x50 = %h", ifu_rdata);
        tick();
    endtask

    task automatic test_random;
        int starve = 0;
        bit rmw = 0, rmw_next;
        int rmw_w = 0;
        logic [31:0] rmw_val = '0;
        bit ev_i = 0, ev_l = 0, e_ig, e_lg;
        logic [31:0] ed_i = '0, ed_l = '0;
        int i_w = 0, l_w = 0;
        for (int w = 64; w < 80; w++) preload(w, $urandom);
        for (int c = 0; c < 400; c++) begin
            if (!ifu_req && ($urandom_range(9) < 6)) begin
                i_w = 64 + $urandom_range(15);
                ifu_req = 1'b1;
                ifu_addr = {14'($urandom), 16'(i_w), 2'($urandom)};
            end
            if (!lsu_req && ($urandom_range(9) < 6)) begin
                l_w = 64 + $urandom_range(15);
                lsu_req = 1'b1;
                lsu_we = 1'($urandom);
                lsu_addr = {14'($urandom), 16'(l_w), 2'($urandom)};
                case ($urandom_range(3))
                    0: lsu_be = 4'hF;
                    1: lsu_be = 4'h0;
                    default: lsu_be = 4'($urandom);
                endcase
                lsu_wdata = $urandom;
            end
            @(negedge CLK);
            if (rmw) begin
                e_ig = 0; e_lg = 0;
                total++;
                if ({mem_we, mem_adr, mem_d} !== {1'b1, 32'(rmw_w), rmw_val}) begin
                    bad++; $display("FAIL rnd_rmw c=%0d: got we=%b adr=%h d=%h want 1/%h/%h",
                                    c, mem_we, mem_adr, mem_d, rmw_w, rmw_val);
                end
            end else begin
                e_ig = ifu_req && (!lsu_req || starve == LIMIT);
                e_lg = lsu_req && !e_ig;
                if (e_ig || e_lg) begin
                    total++;
                    if ({mem_adr, mem_we} !== {32'(e_ig ? i_w : l_w), e_lg && lsu_we && lsu_be == 4'hF}) begin
                        bad++; $display("FAIL rnd_access c=%0d: got adr=%h we=%b", c, mem_adr, mem_we);
                    end
                end
            end
            total++;
            if ({ifu_gnt, lsu_gnt} !== {e_ig, e_lg}) begin
                bad++; $display("FAIL rnd_gnt c=%0d: got i=%b l=%b want i=%b l=%b", c, ifu_gnt, lsu_gnt, e_ig, e_lg);
            end
            total++;
            if ({ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata} !==
                {ev_i, ev_i ? ed_i : 32'h0, ev_l, ev_l ? ed_l : 32'h0}) begin
                bad++; $display("FAIL rnd_rdata c=%0d: got iv=%b id=%h lv=%b ld=%h want iv=%b id=%h lv=%b ld=%h",
                                c, ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata, ev_i, ed_i, ev_l, ed_l);
            end
            if (e_ig) $display("rnd c=%0d IFU read word %0d", c, i_w);
            if (e_lg) $display("rnd c=%0d LSU %s word %0d be=%h", c, lsu_we ? "store" : "load", l_w, lsu_be);
            // Advance the reference model.
            ev_i = e_ig; ed_i = ref_mem[i_w];
            ev_l = e_lg && !lsu_we; ed_l = ref_mem[l_w];
            rmw_next = 0;
            if (e_lg && lsu_we && lsu_be != 4'h0) begin
                ref_mem[l_w] = merge(ref_mem[l_w], lsu_wdata, lsu_be);
                if (lsu_be != 4'hF) begin
                    rmw_next = 1; rmw_w = l_w; rmw_val = ref_mem[l_w];
                end
            end
            if (!rmw) begin
                if (e_ig || !ifu_req) starve = 0;
                else if (e_lg && starve < LIMIT) starve++;
            end
            rmw = rmw_next;
            tick();
            if (e_ig) ifu_req = 1'b0;
            if (e_lg) begin lsu_req = 1'b0; lsu_we = 1'b0; end
        end
        ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
        tick(); tick(); tick();
        for (int w = 64; w < 80; w++) begin
            total++;
            if (mem_array[w] !== ref_mem[w]) begin
                bad++; $display("FAIL rnd_mem[%0d]: got %h want %h", w, mem_array[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_full_store();
        test_partial_store();
        test_starvation();
        test_reset_rmw();
        test_be_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccm_arbiter.md
Name: ccm_arbiter

Overview:
- Shares one single-port closely-coupled memory macro (32-bit word, 1-cycle synchronous read, word-only write) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the RV32I core.
- Grants one access per cycle and routes read data back to the owner.
- Turns LSU sub-word stores into a 2-cycle read-modify-write sequence, because the macro has no byte enables.
- Sits between the core front-end/LSU and the memory macro's CLK/ADR/D/Q/WE pins.

Parameters:
ADDR_W, 16, word-address bits forwarded to the macro (depth = 2^ADDR_W words)
STARVE_LIMIT, 4, max consecutive LSU grants while ifu_req is held before IFU is forced to win one cycle

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
ifu_req  input  1  IFU read request; held with ifu_addr until ifu_gnt
ifu_addr  input  32  IFU byte address
ifu_gnt  output  1  IFU request accepted this cycle
ifu_rvalid  output  1  IFU read data valid (cycle after ifu_gnt)
ifu_rdata  output  32  IFU read data
lsu_req  input  1  LSU request; held with all lsu_* inputs until lsu_gnt
lsu_we  input  1  1 = store, 0 = load
lsu_addr  input  32  LSU byte address
lsu_be  input  4  store byte enables, bit i selects byte i
lsu_wdata  input  32  store data, byte lanes aligned to the word
lsu_gnt  output  1  LSU request accepted this cycle
lsu_rvalid  output  1  LSU load data valid (cycle after lsu_gnt for loads only)
lsu_rdata  output  32  LSU load data
mem_adr  output  32  macro word address = {zeros, addr[ADDR_W+1:2]}
mem_d  output  32  macro write data
mem_we  output  1  macro write enable
mem_q  input  32  macro read data (valid the cycle after a read is presented)

Behaviour:
- Clock is CLK; reset is RST, synchronous and active-high.
- Reset values:
  - All outputs 0.
  - FSM = IDLE, starve counter = 0, response owner = none.
  - While RST=1: no grants; mem_we=0.
- States:
  - IDLE: one access per cycle.
  - RMW_WR: second cycle of a partial store.
- IDLE arbitration (gnt is combinational from req/state, and addresses the macro in the same cycle):
  - Only one requester active: it wins.
  - Both active: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - starve_cnt increments on each LSU grant while ifu_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on IFU grant or when ifu_req=0.
- IDLE access types:
  - IFU grant or LSU load: mem_we=0, mem_adr from the winner's address. Next cycle the owner's rvalid=1 and rdata=mem_q. Non-owner rdata=0.
  - LSU store, lsu_be=4'hF: mem_we=1, mem_d=lsu_wdata, single cycle, no rvalid.
  - LSU store, lsu_be=4'h0: granted, no-op. mem_we=0, no rvalid.
  - LSU store, other lsu_be:
    - Grant cycle issues a read (mem_we=0).
    - Latch addr, be and wdata; go to RMW_WR.
- RMW_WR (one cycle):
  - mem_adr = latched address, mem_we=1.
  - mem_d byte i = be[i] ? wdata byte i : mem_q byte i.
  - No grants, even if requests are pending; starve_cnt holds.
  - Return to IDLE.
- Ordering and timing:
  - Accesses complete in grant order.
  - A read granted the cycle after RMW_WR returns the merged data.
  - Peak throughput 1 access/cycle; partial store costs 2 cycles.
- Address:
  - addr[1:0] ignored (misalignment is the LSU's responsibility).
  - Bits above ADDR_W+1 ignored.
- Reset mid-operation:
  - RST in RMW_WR aborts the write (mem_we=0); memory is unchanged.
  - Pending rvalid is cleared.

Test Plan:
- Word 4 preloaded 0xDEADBEEF; ifu_req, ifu_addr=0x10 -> same-cycle ifu_gnt=1, mem_adr=4, mem_we=0; next cycle ifu_rvalid=1, ifu_rdata=0xDEADBEEF, lsu_rvalid=0.
- LSU store 0x40, wdata 0x12345678, be=4'hF -> lsu_gnt and mem_we=1 in one cycle, mem_adr=0x10; then IFU read 0x40 -> ifu_rdata=0x12345678.
- Word at 0x20 = 0x11223344; LSU store be=4'b0010, wdata=0x0000AB00, ifu_req held -> cycle 1 lsu_gnt, mem_we=0; cycle 2 mem_we=1, mem_d=0x1122AB44, ifu_gnt=0; cycle 3 ifu_gnt=1.
- ifu_req and lsu_req (loads) held continuously, STARVE_LIMIT=4 -> grant sequence L,L,L,L,I,L,L,L,L,I; each rvalid lands on the correct owner one cycle after its grant.
- RST asserted during RMW_WR of a be=4'b0001 store -> mem_we=0 that cycle, target word unchanged, all outputs 0 the next cycle.
- LSU store with be=4'h0 -> lsu_gnt=1, mem_we stays 0, no rvalid, memory unchanged.
